// File: rtl/neopixel_rx_decoder_pkg.sv
// neopix_rx_pkg: receiver FSM states and 50 MHz default NeoPixel timing.
package neopix_rx_pkg;
    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} rx_state_t;
    localparam int NP_NUM_PIXELS   = 8;
    localparam int NP_BIT1_THRESH  = 27;
    localparam int NP_MIN_HIGH     = 8;
    localparam int NP_MAX_HIGH     = 60;
    localparam int NP_LATCH_CYCLES = 1250;
    localparam int NP_CNT_W        = 12;
endpackage

// File: rtl/neopixel_input_sync.sv
// neopixel_input_sync: 2-flop synchronizer on the raw NP line plus edge detect.
module neopixel_input_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_data,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta, r_sync, r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_data;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;
endmodule

// File: rtl/neopixel_rx_decoder.sv
// neopixel_rx_decoder: decodes a NeoPixel stream by high-pulse width into GRB pixel
// strobes, with a frame summary on the latch gap and error strobes for bad pulses.
module neopixel_rx_decoder
    import neopix_rx_pkg::*;
#(
    parameter int NUM_PIXELS   = NP_NUM_PIXELS,
    parameter int BIT1_THRESH  = NP_BIT1_THRESH,
    parameter int MIN_HIGH     = NP_MIN_HIGH,
    parameter int MAX_HIGH     = NP_MAX_HIGH,
    parameter int LATCH_CYCLES = NP_LATCH_CYCLES
)(
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic                          neopixel_data,
    output logic [7:0]                    green,
    output logic [7:0]                    red,
    output logic [7:0]                    blue,
    output logic [$clog2(NUM_PIXELS)-1:0] pixel,
    output logic                          pixel_valid,
    output logic                          frame_done,
    output logic [$clog2(NUM_PIXELS):0]   pixel_count,
    output logic                          error
);
    localparam int PW  = $clog2(NUM_PIXELS);
    localparam int PCW = PW + 1;
    localparam int LW  = NP_CNT_W + 1;
    localparam logic [LW-1:0]  L_MIN   = LW'(MIN_HIGH);
    localparam logic [LW-1:0]  L_MAX   = LW'(MAX_HIGH);
    localparam logic [LW-1:0]  L_BIT1  = LW'(BIT1_THRESH);
    localparam logic [LW-1:0]  L_LATCH = LW'(LATCH_CYCLES);
    localparam logic [PCW-1:0] L_NP    = PCW'(NUM_PIXELS);

    rx_state_t            r_state, w_next;
    logic                 w_level, w_rise, w_fall;
    logic [NP_CNT_W-1:0]  r_cnt;
    logic [LW-1:0]        w_len;
    logic [23:0]          r_sr, w_sr_next;
    logic [4:0]           r_bit;
    logic [PCW-1:0]       r_pix;
    logic                 r_ovf;
    logic                 w_glitch, w_shift, w_frame_end, w_pix_done;

    neopixel_input_sync u_sync (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset_n),
        .i_data  (neopixel_data),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Cycles since the last edge; w_len is the length of the current level including this cycle.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (w_rise || w_fall)
            r_cnt <= '0;
        else if (r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
    end

    assign w_len = {1'b0, r_cnt} + LW'(1);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            r_state <= SYNC;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SYNC: if (!w_level && w_len >= L_LATCH) w_next = IDLE;
            IDLE: if (w_rise) w_next = HIGH;
            HIGH: w_next = (w_len > L_MAX || (w_fall && w_len < L_MIN)) ? SYNC : w_fall ? LOW : HIGH;
            LOW:  w_next = w_rise ? HIGH : (w_len >= L_LATCH) ? IDLE : LOW;
            default: w_next = SYNC;
        endcase
    end

    always_comb begin
        w_glitch    = (r_state == HIGH) && (w_len > L_MAX || (w_fall && w_len < L_MIN));
        w_shift     = (r_state == HIGH) && w_fall && !w_glitch;
        w_frame_end = (r_state == LOW) && !w_rise && w_len >= L_LATCH;
        w_sr_next   = {r_sr[22:0], w_len >= L_BIT1};
        w_pix_done  = w_shift && r_bit == 5'd23;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_sr        <= '0;
            r_bit       <= '0;
            r_pix       <= '0;
            r_ovf       <= 1'b0;
            green       <= '0;
            red         <= '0;
            blue        <= '0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            pixel_count <= '0;
            error       <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            error       <= w_glitch;
            if (w_shift) begin
                r_sr  <= w_sr_next;
                r_bit <= w_pix_done ? 5'd0 : r_bit + 5'd1;
            end
            // Pixels beyond the frame size are only remembered as overflow.
            if (w_pix_done) begin
                if (r_pix < L_NP) begin
                    pixel_valid <= 1'b1;
                    green       <= w_sr_next[23:16];
                    red         <= w_sr_next[15:8];
                    blue        <= w_sr_next[7:0];
                    pixel       <= r_pix[PW-1:0];
                    r_pix       <= r_pix + PCW'(1);
                end else begin
                    r_ovf <= 1'b1;
                end
            end
            if (w_frame_end) begin
                frame_done  <= 1'b1;
                pixel_count <= r_pix;
                error       <= (r_bit != 5'd0) || r_ovf;
            end
            if (w_glitch || w_frame_end) begin
                r_bit <= '0;
                r_pix <= '0;
                r_ovf <= 1'b0;
            end
        end
    end
endmodule
